// File: rtl/z3_target_seq.sv
`default_nettype none
// ============================================================================
// Module      : z3_target_seq
// Description : Zorro III target-side cycle sequencer. Selects a decode
//               window, frames data phases, and drives acknowledge, bus-error
//               and multiple-transfer handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module z3_target_seq #(
  parameter int                 NUM_WIN        = 2,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 TIMEOUT_CYCLES = 255,
  parameter logic [NUM_WIN-1:0] MT_MASK        = '1
) (
  input  logic               CLK,
  input  logic               IORST_n,
  input  logic               FCS_n,
  input  logic [3:0]         DS_n,
  input  logic               MTCR_n,
  input  logic               READ,
  input  logic               DOE,
  input  logic [2:0]         FC,
  input  logic [NUM_WIN-1:0] win_match,
  input  logic [NUM_WIN-1:0] win_ack,
  output logic [NUM_WIN-1:0] sel,
  output logic [2:0]         z3_state,
  output logic               xfer_strobe,
  output logic [3:0]         byte_en,
  output logic               dtack,
  output logic               berr,
  output logic               mtack
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_END     = 3'd3,
    S_MT_WAIT = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  // Bus strobe synchronizers; they rest at the deasserted (high) level
  logic [SYNC_STAGES-1:0]      r_fcs_sync;
  logic [SYNC_STAGES-1:0]      r_mtcr_sync;
  logic [SYNC_STAGES-1:0][3:0] r_ds_sync;

  logic       fcs_s;
  logic       mtcr_s;
  logic [3:0] ds_s;

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      r_fcs_sync  <= '1;
      r_mtcr_sync <= '1;
      r_ds_sync   <= '1;
    end else begin
      r_fcs_sync  <= {r_fcs_sync[SYNC_STAGES-2:0], FCS_n};
      r_mtcr_sync <= {r_mtcr_sync[SYNC_STAGES-2:0], MTCR_n};
      r_ds_sync   <= {r_ds_sync[SYNC_STAGES-2:0], DS_n};
    end
  end

  assign fcs_s  = r_fcs_sync[SYNC_STAGES-1];
  assign mtcr_s = r_mtcr_sync[SYNC_STAGES-1];
  assign ds_s   = r_ds_sync[SYNC_STAGES-1];

  state_t               r_state;
  logic [NUM_WIN-1:0]   r_sel;
  logic [3:0]           r_byte_en;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_xfer;
  logic                 r_dtack;
  logic                 r_berr;
  logic                 r_mtack;

  logic [NUM_WIN-1:0]   w_first_match;
  logic                 w_fc_ok;
  logic                 w_ds_any;
  logic                 w_own_ack;
  logic                 w_mt_first;
  logic                 w_mt_sel;
  logic                 w_data_go;
  logic                 w_mt_go;
  logic                 w_to_idle;
  logic                 w_unused_fc2;

  // Two's-complement trick isolates the lowest set match bit
  assign w_first_match = win_match & (~win_match + NUM_WIN'(1));
  assign w_fc_ok       = FC[1] ^ FC[0];
  assign w_unused_fc2  = FC[2];
  assign w_ds_any      = (ds_s != 4'hF);
  assign w_own_ack     = |(win_ack & r_sel);
  assign w_mt_first    = |(MT_MASK & w_first_match);
  assign w_mt_sel      = |(MT_MASK & r_sel);
  assign w_data_go     = READ | (w_ds_any & DOE);
  assign w_mt_go       = ~mtcr_s & (ds_s == 4'hF) & w_mt_sel;
  // Cycle end aborts every non-idle state; unused codes also fall back to idle
  assign w_to_idle     = fcs_s ? (r_state != S_IDLE) : (r_state > S_ERR);

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_byte_en <= '0;
      r_cnt     <= '0;
      r_xfer    <= 1'b0;
      r_dtack   <= 1'b0;
      r_berr    <= 1'b0;
      r_mtack   <= 1'b0;
    end else begin
      r_xfer <= 1'b0;
      if (w_to_idle) begin
        r_state   <= S_IDLE;
        r_sel     <= '0;
        r_byte_en <= '0;
        r_cnt     <= '0;
        r_dtack   <= 1'b0;
        r_berr    <= 1'b0;
        r_mtack   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!fcs_s && (|win_match) && w_fc_ok) begin
              r_state <= S_START;
              r_sel   <= w_first_match;
              r_mtack <= w_mt_first;
            end
          end
          S_START: begin
            if (w_data_go) begin
              r_state   <= S_DATA;
              r_byte_en <= ~ds_s;
              r_cnt     <= '0;
              r_xfer    <= 1'b1;
            end
          end
          S_DATA: begin
            if (w_own_ack) begin
              r_state <= S_END;
              r_dtack <= 1'b1;
            end else if (r_cnt == c_CNT_LAST) begin
              r_state <= S_ERR;
              r_berr  <= 1'b1;
              r_mtack <= 1'b0;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
          S_END: begin
            if (w_mt_go) begin
              r_state <= S_MT_WAIT;
              r_dtack <= 1'b0;
            end
          end
          S_MT_WAIT: begin
            if (w_ds_any) begin
              r_state   <= S_DATA;
              r_byte_en <= ~ds_s;
              r_cnt     <= '0;
              r_xfer    <= 1'b1;
            end
          end
          // Error is held until the master ends the cycle
          default: begin
          end
        endcase
      end
    end
  end

  assign sel         = r_sel;
  assign z3_state    = r_state;
  assign xfer_strobe = r_xfer;
  assign byte_en     = r_byte_en;
  assign dtack       = r_dtack;
  assign berr        = r_berr;
  assign mtack       = r_mtack;

endmodule
`default_nettype wire

// File: tb/tb_z3_target_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_z3_target_seq
// Description : Self-checking bench for z3_target_seq; directed scenarios plus
//               randomized bus activity against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_z3_target_seq;

  localparam int NUM_WIN        = 2;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 4;
  localparam logic [NUM_WIN-1:0] MT_MASK = 2'b01;
  localparam int OUT_W = 3 + NUM_WIN + 1 + 4 + 3;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_START = 3'd1;
  localparam logic [2:0] P_DATA  = 3'd2;
  localparam logic [2:0] P_END   = 3'd3;
  localparam logic [2:0] P_MTW   = 3'd4;
  localparam logic [2:0] P_ERR   = 3'd5;

  logic               CLK = 1'b0;
  logic               IORST_n = 1'b0;
  logic               FCS_n = 1'b1;
  logic [3:0]         DS_n = 4'hF;
  logic               MTCR_n = 1'b1;
  logic               READ = 1'b0;
  logic               DOE = 1'b0;
  logic [2:0]         FC = 3'd0;
  logic [NUM_WIN-1:0] win_match = '0;
  logic [NUM_WIN-1:0] win_ack = '0;
  logic [NUM_WIN-1:0] sel;
  logic [2:0]         z3_state;
  logic               xfer_strobe;
  logic [3:0]         byte_en;
  logic               dtack;
  logic               berr;
  logic               mtack;

  int vectors = 0;
  int miscompares = 0;

  z3_target_seq #(
    .NUM_WIN(NUM_WIN), .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MT_MASK(MT_MASK)
  ) dut (
    .CLK(CLK), .IORST_n(IORST_n), .FCS_n(FCS_n), .DS_n(DS_n), .MTCR_n(MTCR_n),
    .READ(READ), .DOE(DOE), .FC(FC), .win_match(win_match), .win_ack(win_ack),
    .sel(sel), .z3_state(z3_state), .xfer_strobe(xfer_strobe), .byte_en(byte_en),
    .dtack(dtack), .berr(berr), .mtack(mtack)
  );

  always #5 CLK = ~CLK;

  // Transaction-level reference: phase, selected window index, DATA cycles spent
  typedef struct {
    logic [2:0]                  ph;
    int                          idx;
    logic [3:0]                  be;
    int                          dcyc;
    logic                        xfer;
    logic [SYNC_STAGES-1:0]      fh;
    logic [SYNC_STAGES-1:0]      mh;
    logic [SYNC_STAGES-1:0][3:0] dh;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.ph = P_IDLE; r.idx = -1; r.be = 4'h0; r.dcyc = 0; r.xfer = 1'b0;
    r.fh = '1; r.mh = '1; r.dh = '1;
    return r;
  endfunction

  function automatic int lowest_set(input logic [NUM_WIN-1:0] v);
    for (int i = 0; i < NUM_WIN; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic model_t model_step(input model_t c);
    model_t     n;
    logic       fs;
    logic       ms;
    logic [3:0] dss;
    logic       own_ack;
    n   = c;
    fs  = c.fh[SYNC_STAGES-1];
    ms  = c.mh[SYNC_STAGES-1];
    dss = c.dh[SYNC_STAGES-1];
    n.fh = {c.fh[SYNC_STAGES-2:0], FCS_n};
    n.mh = {c.mh[SYNC_STAGES-2:0], MTCR_n};
    n.dh = {c.dh[SYNC_STAGES-2:0], DS_n};
    n.xfer = 1'b0;
    own_ack = (c.idx >= 0) ? win_ack[c.idx] : 1'b0;
    if (fs && c.ph != P_IDLE) begin
      n.ph = P_IDLE; n.idx = -1; n.be = 4'h0; n.dcyc = 0;
    end else begin
      case (c.ph)
        P_IDLE:
          if (win_match != '0 && (FC[1] != FC[0]) && !fs) begin
            n.ph = P_START; n.idx = lowest_set(win_match);
          end
        P_START:
          if (READ || (dss != 4'hF && DOE)) begin
            n.ph = P_DATA; n.be = ~dss; n.dcyc = 1; n.xfer = 1'b1;
          end
        P_DATA:
          if (own_ack) n.ph = P_END;
          else if (c.dcyc >= TIMEOUT_CYCLES) n.ph = P_ERR;
          else n.dcyc = c.dcyc + 1;
        P_END:
          if (!ms && dss == 4'hF && MT_MASK[c.idx]) n.ph = P_MTW;
        P_MTW:
          if (dss != 4'hF) begin
            n.ph = P_DATA; n.be = ~dss; n.dcyc = 1; n.xfer = 1'b1;
          end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [OUT_W-1:0] model_outs(input model_t c);
    logic [NUM_WIN-1:0] s;
    logic               mt;
    s = '0; mt = 1'b0;
    if (c.idx >= 0) begin
      s[c.idx] = 1'b1;
      mt = MT_MASK[c.idx] && (c.ph inside {P_START, P_DATA, P_END, P_MTW});
    end
    return {c.ph, s, c.xfer, c.be, (c.ph == P_END), (c.ph == P_ERR), mt};
  endfunction

  function automatic logic [OUT_W-1:0] dut_outs();
    return {z3_state, sel, xfer_strobe, byte_en, dtack, berr, mtack};
  endfunction

  always @(posedge CLK or negedge IORST_n)
    if (!IORST_n) m <= model_reset();
    else          m <= model_step(m);

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_idle();
    FCS_n = 1'b1; DS_n = 4'hF; MTCR_n = 1'b1; READ = 1'b0; DOE = 1'b0;
    FC = 3'd0; win_match = '0; win_ack = '0;
  endtask

  task automatic test_reset();
    IORST_n = 1'b0; bus_idle(); cyc(3);
    vectors++;
    if (dut_outs() !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %b, expected all zero", dut_outs());
    end
    IORST_n = 1'b1; cyc(3);
    vectors++;
    if (dut_outs() !== model_outs(m) || dut_outs() !== '0) begin
      miscompares++; $display("FAIL reset_idle: got %b, expected %b", dut_outs(), model_outs(m));
    end
  endtask

  task automatic test_read();
    int n;
    bus_idle(); cyc(4);
    win_match = 2'b11; FC = 3'd1; READ = 1'b1; FCS_n = 1'b0;
    n = 0;
    while (z3_state !== P_START && n < 12) begin @(negedge CLK); n++; end
    vectors++;
    if (z3_state !== P_START || sel !== 2'b01 || n != SYNC_STAGES + 1) begin
      miscompares++;
      $display("FAIL read_start: state=%0d sel=%b lat=%0d, expected state=1 sel=01 lat=%0d",
               z3_state, sel, n, SYNC_STAGES + 1);
    end
    @(negedge CLK);
    vectors++;
    if (z3_state !== P_DATA || xfer_strobe !== 1'b1) begin
      miscompares++; $display("FAIL read_data_entry: state=%0d xfer=%b, expected 2/1", z3_state, xfer_strobe);
    end
    win_match = 2'b10; win_ack = 2'b10;
    @(negedge CLK);
    vectors++;
    if (z3_state !== P_DATA || xfer_strobe !== 1'b0 || sel !== 2'b01) begin
      miscompares++;
      $display("FAIL read_data_hold: state=%0d xfer=%b sel=%b, expected 2/0/01", z3_state, xfer_strobe, sel);
    end
    @(negedge CLK);
    win_ack = 2'b01;
    @(negedge CLK);
    vectors++;
    if (z3_state !== P_END || dtack !== 1'b1 || sel !== 2'b01) begin
      miscompares++; $display("FAIL read_ack: state=%0d dtack=%b sel=%b, expected 3/1/01", z3_state, dtack, sel);
    end
    win_ack = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      vectors++;
      if (z3_state !== P_END || dtack !== 1'b1) begin
        miscompares++; $display("FAIL read_end_hold: state=%0d dtack=%b, expected 3/1", z3_state, dtack);
      end
    end
    FCS_n = 1'b1;
    for (int k = 0; k < SYNC_STAGES; k++) begin
      @(negedge CLK);
      vectors++;
      if (dtack !== 1'b1) begin
        miscompares++; $display("FAIL read_dtack_tail: cycle %0d dtack=%b, expected 1", k, dtack);
      end
    end
    @(negedge CLK);
    vectors++;
    if (z3_state !== P_IDLE || dtack !== 1'b0 || sel !== '0) begin
      miscompares++; $display("FAIL read_release: state=%0d dtack=%b sel=%b, expected 0/0/00", z3_state, dtack, sel);
    end
  endtask

  task automatic test_write();
    int n;
    bus_idle(); cyc(4);
    win_match = 2'b01; FC = 3'd2; DS_n = 4'b1100; FCS_n = 1'b0;
    n = 0;
    while (z3_state !== P_START && n < 12) begin @(negedge CLK); n++; end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      vectors++;
      if (z3_state !== P_START) begin
        miscompares++; $display("FAIL write_doe_low: state=%0d, expected 1", z3_state);
      end
    end
    DOE = 1'b1;
    @(negedge CLK);
    vectors++;
    if (z3_state !== P_DATA || byte_en !== 4'b0011 || xfer_strobe !== 1'b1) begin
      miscompares++;
      $display("FAIL write_byte_en: state=%0d be=%b xfer=%b, expected 2/0011/1", z3_state, byte_en, xfer_strobe);
    end
    win_ack = 2'b01;
    @(negedge CLK);
    win_ack = '0; FCS_n = 1'b1; DS_n = 4'hF; DOE = 1'b0;
    n = 0;
    while (z3_state !== P_IDLE && n < 12) begin @(negedge CLK); n++; end
    vectors++;
    if (z3_state !== P_IDLE || byte_en !== 4'b0000) begin
      miscompares++; $display("FAIL write_release: state=%0d be=%b, expected 0/0000", z3_state, byte_en);
    end
  endtask

  task automatic test_timeout();
    int n;
    bus_idle(); cyc(4);
    win_match = 2'b01; FC = 3'd1; READ = 1'b1; FCS_n = 1'b0;
    n = 0;
    while (z3_state !== P_DATA && n < 12) begin @(negedge CLK); n++; end
    n = 0;
    while (z3_state === P_DATA && n < 20) begin n++; @(negedge CLK); end
    vectors++;
    if (n != TIMEOUT_CYCLES || z3_state !== P_ERR || berr !== 1'b1 || mtack !== 1'b0 || dtack !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_entry: data_cycles=%0d state=%0d berr=%b mtack=%b dtack=%b, expected %0d/5/1/0/0",
               n, z3_state, berr, mtack, dtack, TIMEOUT_CYCLES);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      vectors++;
      if (z3_state !== P_ERR || berr !== 1'b1) begin
        miscompares++; $display("FAIL timeout_hold: state=%0d berr=%b, expected 5/1", z3_state, berr);
      end
    end
    FCS_n = 1'b1;
    n = 0;
    while (z3_state !== P_IDLE && n < 12) begin @(negedge CLK); n++; end
    vectors++;
    if (z3_state !== P_IDLE || berr !== 1'b0) begin
      miscompares++; $display("FAIL timeout_release: state=%0d berr=%b, expected 0/0", z3_state, berr);
    end
  endtask

  task automatic test_ack_at_timeout();
    int n;
    bus_idle(); cyc(4);
    win_match = 2'b01; FC = 3'd1; READ = 1'b1; FCS_n = 1'b0;
    n = 0;
    while (z3_state !== P_DATA && n < 12) begin @(negedge CLK); n++; end
    cyc(TIMEOUT_CYCLES - 1);
    win_ack = 2'b01;
    @(negedge CLK);
    vectors++;
    if (z3_state !== P_END || dtack !== 1'b1 || berr !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_vs_timeout: state=%0d dtack=%b berr=%b, expected 3/1/0", z3_state, dtack, berr);
    end
    win_ack = '0; FCS_n = 1'b1;
    n = 0;
    while (z3_state !== P_IDLE && n < 12) begin @(negedge CLK); n++; end
  endtask

  task automatic test_multi();
    int n, xfers, dts, drops, seen_mt;
    logic [3:0] lanes [3];
    lanes[0] = 4'b1110; lanes[1] = 4'b0000; lanes[2] = 4'b0101;
    xfers = 0; dts = 0; drops = 0; seen_mt = 0;
    bus_idle(); cyc(4);
    win_match = 2'b01; FC = 3'd1; DOE = 1'b1; MTCR_n = 1'b0; FCS_n = 1'b0;
    n = 0;
    while (z3_state !== P_START && n < 12) begin @(negedge CLK); n++; end
    for (int t = 0; t < 3; t++) begin
      DS_n = lanes[t];
      n = 0;
      while (z3_state !== P_DATA && n < 12) begin
        @(negedge CLK); n++;
        if (mtack !== 1'b1) drops++;
      end
      if (xfer_strobe === 1'b1) xfers++;
      vectors++;
      if (z3_state !== P_DATA || byte_en !== ~lanes[t]) begin
        miscompares++;
        $display("FAIL mt_data_%0d: state=%0d be=%b, expected 2/%b", t, z3_state, byte_en, ~lanes[t]);
      end
      win_ack = 2'b01;
      @(negedge CLK);
      if (xfer_strobe === 1'b1) xfers++;
      if (z3_state === P_END && dtack === 1'b1) dts++;
      if (mtack !== 1'b1) drops++;
      win_ack = '0; DS_n = 4'hF;
      n = 0;
      while (z3_state !== P_MTW && n < 12) begin
        @(negedge CLK); n++;
        if (xfer_strobe === 1'b1) xfers++;
        if (mtack !== 1'b1) drops++;
      end
      vectors++;
      if (z3_state !== P_MTW || dtack !== 1'b0 || sel !== 2'b01) begin
        miscompares++;
        $display("FAIL mt_wait_%0d: state=%0d dtack=%b sel=%b, expected 4/0/01", t, z3_state, dtack, sel);
      end
    end
    vectors++;
    if (xfers != 3 || dts != 3 || drops != 0) begin
      miscompares++;
      $display("FAIL mt_counts: xfers=%0d dtacks=%0d mtack_drops=%0d, expected 3/3/0", xfers, dts, drops);
    end
    FCS_n = 1'b1;
    n = 0;
    while (z3_state !== P_IDLE && n < 12) begin @(negedge CLK); n++; end
    bus_idle(); cyc(4);
    win_match = 2'b10; FC = 3'd1; DOE = 1'b1; MTCR_n = 1'b0; DS_n = 4'b0000; FCS_n = 1'b0;
    n = 0;
    while (z3_state !== P_DATA && n < 12) begin @(negedge CLK); n++; end
    win_ack = 2'b10;
    @(negedge CLK);
    win_ack = '0; DS_n = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (z3_state === P_MTW) seen_mt++;
    end
    vectors++;
    if (z3_state !== P_END || seen_mt != 0 || dtack !== 1'b1 || mtack !== 1'b0 || sel !== 2'b10) begin
      miscompares++;
      $display("FAIL mt_masked: state=%0d mt_wait_cycles=%0d dtack=%b mtack=%b sel=%b, expected 3/0/1/0/10",
               z3_state, seen_mt, dtack, mtack, sel);
    end
    FCS_n = 1'b1;
    n = 0;
    while (z3_state !== P_IDLE && n < 12) begin @(negedge CLK); n++; end
  endtask

  task automatic test_fc_reject();
    int bad;
    logic [2:0] codes [4];
    codes[0] = 3'b000; codes[1] = 3'b011; codes[2] = 3'b100; codes[3] = 3'b111;
    for (int c = 0; c < 4; c++) begin
      bus_idle(); cyc(4);
      win_match = 2'b11; FC = codes[c]; READ = 1'b1; FCS_n = 1'b0;
      bad = 0;
      repeat (8) begin
        @(negedge CLK);
        if (dut_outs() !== '0) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++; $display("FAIL fc_reject FC=%b: %0d active cycles, expected 0", codes[c], bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    bus_idle(); cyc(4);
    win_match = 2'b01; FC = 3'd1; READ = 1'b1; FCS_n = 1'b0;
    n = 0;
    while (z3_state !== P_DATA && n < 12) begin @(negedge CLK); n++; end
    win_ack = 2'b01;
    @(negedge CLK);
    #2 IORST_n = 1'b0;
    #1;
    vectors++;
    if (dut_outs() !== '0) begin
      miscompares++; $display("FAIL reset_in_end: got %b, expected all zero", dut_outs());
    end
    win_ack = '0;
    @(negedge CLK);
    IORST_n = 1'b1;
    bad = 0;
    for (int k = 0; k < SYNC_STAGES; k++) begin
      @(negedge CLK);
      if (z3_state !== P_IDLE) bad++;
    end
    @(negedge CLK);
    vectors++;
    if (bad != 0 || z3_state !== P_START) begin
      miscompares++;
      $display("FAIL reset_resync: early_cycles=%0d state=%0d, expected 0/1", bad, z3_state);
    end
    FCS_n = 1'b1;
    n = 0;
    while (z3_state !== P_IDLE && n < 12) begin @(negedge CLK); n++; end
  endtask

  task automatic test_random(input int ncyc);
    bus_idle(); cyc(4);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      vectors++;
      if (dut_outs() !== model_outs(m)) begin
        miscompares++;
        $display("FAIL random_cycle %0d: dut=%b model=%b", i, dut_outs(), model_outs(m));
      end
      IORST_n = ($urandom_range(0, 400) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 24) == 0) FCS_n = ~FCS_n;
      if ($urandom_range(0, 3) == 0) DS_n = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 9) == 0) MTCR_n = ~MTCR_n;
      READ = ($urandom_range(0, 3) == 0);
      DOE  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) FC = 3'($urandom);
      if ($urandom_range(0, 7) == 0) win_match = NUM_WIN'($urandom);
      win_ack = ($urandom_range(0, 4) == 0) ? NUM_WIN'($urandom) : '0;
    end
    IORST_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ack_at_timeout();
    test_multi();
    test_fc_reject();
    test_reset_mid();
    test_random(4000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z3_target_seq.md
Z3_TARGET_SEQ -- requirements
Module: z3_target_seq

Interface
REQ-001 Parameter NUM_WIN, default 2: number of decode windows/targets (1..8).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for FCS_n, DS_n, MTCR_n (>=2).
REQ-003 Parameter TIMEOUT_CYCLES, default 255: max DATA-state cycles awaiting target ack (2..4095).
REQ-004 Parameter MT_MASK, default all-ones, width NUM_WIN: per-window multiple-transfer capability.
REQ-005 CLK  in  1  bus-side clock; all logic rising-edge.
REQ-006 IORST_n  in  1  asynchronous active-low reset.
REQ-007 FCS_n  in  1  Zorro III full cycle strobe, asynchronous.
REQ-008 DS_n  in  4  data strobes, asynchronous, active low.
REQ-009 MTCR_n  in  1  multiple-transfer cycle strobe, asynchronous, active low.
REQ-010 READ  in  1  bus direction, 1 = read.
REQ-011 DOE  in  1  data output enable.
REQ-012 FC  in  3  function code.
REQ-013 win_match  in  NUM_WIN  latched address match per window (decoder output, stable while FCS_n low).
REQ-014 win_ack  in  NUM_WIN  per-window target-ready, level.
REQ-015 sel  out  NUM_WIN  one-hot selected window.
REQ-016 z3_state  out  3  current state encoding.
REQ-017 xfer_strobe  out  1  one-cycle pulse at start of each data phase.
REQ-018 byte_en  out  4  active-high byte lanes captured at data-phase start.
REQ-019 dtack  out  1  cycle acknowledge (active high).
REQ-020 berr  out  1  bus error, timeout (active high).
REQ-021 mtack  out  1  multiple-transfer acknowledge (active high).

Function
REQ-022 FCS_n, DS_n, MTCR_n SHALL pass SYNC_STAGES flops; sync outputs fcs_s, ds_s, mtcr_s.
REQ-023 States: IDLE=0, START=1, DATA=2, END=3, MT_WAIT=4, ERR=5; codes 6/7 SHALL go to IDLE next cycle.
REQ-024 IDLE: fcs_s=0, |win_match, FC[1]^FC[0]=1 -> START, sel <= lowest-index set bit of win_match; else sel=0.
REQ-025 START: fcs_s=1 -> IDLE; else READ=1 or (any ds_s=0 and DOE=1) -> DATA; else hold.
REQ-026 Entering DATA (from START or MT_WAIT): byte_en <= ~ds_s, timeout counter <= 0, xfer_strobe=1 for exactly the first DATA cycle.
REQ-027 DATA: fcs_s=1 -> IDLE; else |(win_ack & sel) -> END; else counter = TIMEOUT_CYCLES-1 -> ERR; else counter+1.
REQ-028 Ack takes priority over timeout on the same cycle.
REQ-029 END: dtack=1 every cycle in END; fcs_s=1 -> IDLE.
REQ-030 END, fcs_s=0, mtcr_s=0, ds_s=4'hF, MT_MASK bit of sel=1 -> MT_WAIT.
REQ-031 MT_WAIT: dtack=0; fcs_s=1 -> IDLE; any ds_s=0 -> DATA; sel held.
REQ-032 ERR: berr=1 every cycle; only exit is fcs_s=1 -> IDLE; dtack=0.
REQ-033 mtack=1 in START/DATA/END/MT_WAIT when MT_MASK bit of sel=1, else 0.
REQ-034 Entering IDLE SHALL clear sel, byte_en, dtack, berr, mtack, counter within the same transition.
REQ-035 win_match changes after IDLE exit SHALL NOT alter sel.
REQ-036 Counter width SHALL be clog2(TIMEOUT_CYCLES); no wrap reachable.

Reset
REQ-037 IORST_n low SHALL asynchronously force: state IDLE, sync flops 1, sel=0, byte_en=0, counter=0, xfer_strobe=dtack=berr=mtack=0.
REQ-038 Reset mid-cycle SHALL abort; after release first FCS_n assertion SHALL only be accepted after SYNC_STAGES cycles.

Verification
REQ-039 Read, NUM_WIN=2, win_match=2'b11, FC=1, FCS_n low, win_ack[0] after 3 cycles -> sel=01, xfer_strobe 1 cycle, dtack until FCS_n high +SYNC_STAGES.
REQ-040 Write, DS_n=4'b1100, DOE=1 -> byte_en=4'b0011 in DATA; no DATA entry while DOE=0.
REQ-041 No ack, TIMEOUT_CYCLES=4 -> ERR after 4 DATA cycles, berr held until FCS_n high, then IDLE, berr=0.
REQ-042 MTCR_n low, 3 transfers via DS_n toggling, FCS_n held -> 3 xfer_strobe pulses, 3 dtack intervals, mtack=1 throughout; MT_MASK bit=0 -> no MT_WAIT.
REQ-043 FC=3'b000 or 3'b011 with match -> stays IDLE, no outputs.
REQ-044 IORST_n low during END -> all outputs 0 immediately; ack on same cycle as timeout -> END, not ERR.
